// File: rtl/fetch_pc_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_pc_sequencer
//
// Instruction-fetch front end. This block owns the program counter and keeps a
// request/acknowledge transaction open toward instruction memory. Each
// returned word is buffered with its address in a 2-entry queue, and decode
// drains that queue.
//
// A redirect (branch/jump/exception target) flushes the queue. If a request is
// still outstanding when the redirect arrives, the block keeps that request
// stable until it is acknowledged and then throws the response away (DROP).
// After that it fetches from the new target.
//
// Optional feature, enabled by defining FETCH_ALIGN_CHECK_EN:
//   A misaligned redirect target (redirect_pc[1:0] != 0) sets a sticky fault
//   and halts fetching until reset. Any request still outstanding is first
//   drained as in DROP.
//   When the macro is not defined, the low two target bits are forced to zero,
//   fault is tied low and HALT cannot be reached.
//
// Handshake semantics (both sides):
//   imem:  imem_req/imem_addr stay stable until a cycle with imem_ack=1. That
//          cycle both accepts the request and delivers imem_rdata. When
//          imem_req falls without an ack (reset), the request is cancelled.
//   decode: a transfer happens on a rising edge where inst_valid && inst_ready.
//          inst_valid never depends combinationally on inst_ready.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   imem_req/imem_addr   fetch request and address (imem_addr == pc)
//   imem_ack/imem_rdata  accept + returned word (same cycle)
//   redirect/redirect_pc one-cycle pulse with the new fetch target
//   inst_valid/ready     queue-head handshake toward decode
//   inst_data/inst_pc    queue-head word and its address (hold when empty)
//   pc_out               current fetch PC
//   fault                sticky misaligned-redirect flag
//   state_dbg            FSM state (0=FETCH, 1=DROP, 2=HALT)
// -----------------------------------------------------------------------------
module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_out,
  output logic        fault,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] saved_q, saved_d;
  logic [1:0]  count_q;

  // Queue storage. e0 is always the head, which lets the head outputs hold
  // their last value once the queue drains.
  logic [31:0] e0_pc, e0_word;
  logic [31:0] e1_pc, e1_word;

  logic        fault_q;
  logic        misaligned;
  logic [31:0] tgt;

  logic        outstanding;
  logic        push;
  logic        pop;
  logic        flush;
  logic        halt_pending;

  // ---------------------------------------------------------------------------
  // Redirect target conditioning / alignment check
  // ---------------------------------------------------------------------------
`ifdef FETCH_ALIGN_CHECK_EN
  assign tgt        = redirect_pc;
  assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (misaligned) begin
      fault_q <= 1'b1;
    end
  end
`else
  logic unused_rpc_lsb;
  assign unused_rpc_lsb = ^redirect_pc[1:0];
  assign tgt            = {redirect_pc[31:2], 2'b00};
  assign misaligned     = 1'b0;
  assign fault_q        = 1'b0;
`endif

  // Once a fault is seen (now or earlier), the drain ends in HALT, not FETCH.
  assign halt_pending = fault_q | misaligned;

  // ---------------------------------------------------------------------------
  // Request and handshake decode
  // ---------------------------------------------------------------------------
  // In DROP the request is held at the old address even though the queue may
  // have room, because the memory still owes the cancelled response.
  assign imem_req    = !rst && (((state_q == FETCH) && (count_q < 2'd2)) ||
                                 (state_q == DROP));
  assign outstanding = imem_req && !imem_ack;
  assign push        = (state_q == FETCH) && imem_req && imem_ack && !redirect;
  assign pop         = inst_valid && inst_ready;

  // ---------------------------------------------------------------------------
  // FSM: next state, next pc, saved target
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    saved_d = saved_q;
    flush   = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          flush = 1'b1;
          if (misaligned) begin
            state_d = outstanding ? DROP : HALT;
          end else if (outstanding) begin
            // Keep imem_addr stable; jump once the old request completes.
            saved_d = tgt;
            state_d = DROP;
          end else begin
            // Nothing owed by memory (or ack coincides): the response is
            // discarded and we jump right away.
            pc_d = tgt;
          end
        end else if (push) begin
          pc_d = pc_q + 32'd4;
        end
      end
      DROP: begin
        if (redirect) begin
          flush = 1'b1;
        end
        if (imem_ack) begin
          if (halt_pending) begin
            state_d = HALT;
          end else begin
            // A redirect arriving together with the ack is the latest target.
            state_d = FETCH;
            pc_d    = redirect ? tgt : saved_q;
          end
        end else if (redirect && !halt_pending) begin
          saved_d = tgt;
        end
      end
      default: begin
        // HALT: frozen until reset.
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      saved_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      saved_q <= saved_d;
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry shift queue of {pc, word}
  // ---------------------------------------------------------------------------
  // A pop in a flush cycle still completes toward decode. Only the occupancy is
  // cleared, so the head registers keep showing the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      e0_pc   <= 32'd0;
      e0_word <= 32'd0;
      e1_pc   <= 32'd0;
      e1_word <= 32'd0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase

      if (push) begin
        // push only happens with count_q < 2.
        if ((count_q == 2'd0) || pop) begin
          e0_pc   <= pc_q;
          e0_word <= imem_rdata;
        end else begin
          e1_pc   <= pc_q;
          e1_word <= imem_rdata;
        end
      end else if (pop && (count_q == 2'd2)) begin
        e0_pc   <= e1_pc;
        e0_word <= e1_word;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all from registers)
  // ---------------------------------------------------------------------------
  assign imem_addr  = pc_q;
  assign pc_out     = pc_q;
  assign inst_valid = (count_q != 2'd0);
  assign inst_data  = e0_word;
  assign inst_pc    = e0_pc;
  assign fault      = fault_q;
  assign state_dbg  = state_q;

endmodule
